// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined RV32I control decoder: opcodes, control-word fields
// and the ALU-code helper used by the decoder.
package ctrl_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef struct packed {
    logic        branch;
    logic        jal;
    logic        jalr;
    result_src_e result_src;
    logic        mem_write;
    logic        alu_src_a_pc;
    logic        alu_src_b_imm;
    imm_src_e    imm_src;
    logic        reg_write;
    alu_ctrl_e   alu_ctrl;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

  // ALU code for OP/OP-IMM; SUB exists only in the register form.
  function automatic alu_ctrl_e aluFromFunct(input logic [2:0] funct3, input logic funct7b5,
                                             input logic isReg);
    alu_ctrl_e code;
    case (funct3)
      3'b000:  code = (isReg && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_pipe_decoder_if.sv
// ID-side instruction/control bundle of the pipelined decoder.
interface control_pipe_decoder_if
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CNT_W      = 32
);
  logic [31:0]           instr_i;
  logic                  instr_valid_i;
  logic                  hold_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  illegal_o;
  ctrl_t [NUM_STAGES-1:0] ctrl_o;
  logic [NUM_STAGES-1:0] valid_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport master (
    output instr_i, instr_valid_i, hold_i, flush_i,
    input  stall_o, illegal_o, ctrl_o, valid_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i, hold_i, flush_i,
    output stall_o, illegal_o, ctrl_o, valid_o, stall_cnt_o
  );
endinterface

// File: rtl/control_decode.sv
// Combinational RV32I instruction to control-word decoder, plus source-register use flags.
module control_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        rs1Used,
  output logic        rs2Used
);

  logic [2:0] funct3;
  logic       funct7b5;
  logic       legal;
  logic       unusedBits;

  assign funct3     = instr[14:12];
  assign funct7b5   = instr[30];
  assign unusedBits = ^{instr[31], instr[29:25]};

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    rs1Used = 1'b0;
    rs2Used = 1'b0;
    legal   = 1'b1;
    case (instr[6:0])
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = aluFromFunct(funct3, funct7b5, 1'b1);
        rs1Used        = 1'b1;
        rs2Used        = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write     = 1'b1;
        ctrl.alu_src_b_imm = 1'b1;
        ctrl.alu_ctrl      = aluFromFunct(funct3, funct7b5, 1'b0);
        rs1Used            = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write     = 1'b1;
        ctrl.result_src    = RES_MEM;
        ctrl.alu_src_b_imm = 1'b1;
        rs1Used            = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write     = 1'b1;
        ctrl.alu_src_b_imm = 1'b1;
        ctrl.imm_src       = IMM_S;
        rs1Used            = 1'b1;
        rs2Used            = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.imm_src  = IMM_B;
        ctrl.alu_ctrl = ALU_SUB;
        rs1Used       = 1'b1;
        rs2Used       = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.reg_write     = 1'b1;
        ctrl.alu_src_a_pc  = 1'b1;
        ctrl.alu_src_b_imm = 1'b1;
        ctrl.imm_src       = IMM_U;
      end
      OP_LUI: begin
        ctrl.reg_write     = 1'b1;
        ctrl.alu_src_b_imm = 1'b1;
        ctrl.imm_src       = IMM_U;
        ctrl.alu_ctrl      = ALU_PASSB;
      end
      OP_JAL: begin
        ctrl.jal        = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        ctrl.jalr          = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.result_src    = RES_PC4;
        ctrl.alu_src_b_imm = 1'b1;
        rs1Used            = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Register fields ride along only for recognised opcodes; unknown ones stay all-zero.
    if (legal) begin
      ctrl.funct3 = funct3;
      ctrl.rd     = instr[11:7];
      ctrl.rs1    = instr[19:15];
      ctrl.rs2    = instr[24:20];
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_pipe_decoder.sv
// Pipelined control decoder: decodes in ID, carries the control word through NUM_STAGES
// registered stages and resolves load-use stall, flush and hold.
module control_pipe_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CNT_W      = 32
)
(
  input logic                    clk_i,
  input logic                    rst_i,
  control_pipe_decoder_if.slave  bus
);

  ctrl_t                  dec;
  logic                   rs1Used;
  logic                   rs2Used;
  logic                   stall;
  logic                   rdHit;
  logic                   flushNow;

  ctrl_t [NUM_STAGES-1:0] ctrlQ, ctrlD;
  logic [NUM_STAGES-1:0]  validQ, validD;
  logic [CNT_W-1:0]       stallCntQ, stallCntD;
  logic                   flushPend, flushPendD;

  control_decode uDecode (
    .instr   (bus.instr_i),
    .ctrl    (dec),
    .rs1Used (rs1Used),
    .rs2Used (rs2Used)
  );

  // Load in stage 0 whose destination feeds the instruction now in ID.
  assign rdHit = (rs1Used && (dec.rs1 == ctrlQ[0].rd)) || (rs2Used && (dec.rs2 == ctrlQ[0].rd));
  assign stall = bus.instr_valid_i && validQ[0] && (ctrlQ[0].result_src == RES_MEM) &&
                 (ctrlQ[0].rd != 5'd0) && rdHit && !bus.flush_i && !flushPend;
  assign flushNow = bus.flush_i || flushPend;

  always_comb begin
    ctrlD      = ctrlQ;
    validD     = validQ;
    stallCntD  = stallCntQ;
    flushPendD = flushPend;
    if (bus.hold_i) begin
      if (bus.flush_i) flushPendD = 1'b1;
    end else begin
      ctrlD  = ctrlQ << CTRL_W;
      validD = validQ << 1;
      if (flushNow) begin
        ctrlD[0]   = CTRL_BUBBLE;
        validD[0]  = 1'b0;
        flushPendD = 1'b0;
      end else if (stall) begin
        ctrlD[0]  = CTRL_BUBBLE;
        validD[0] = 1'b0;
        if (stallCntQ != '1) stallCntD = stallCntQ + CNT_W'(1);
      end else begin
        ctrlD[0]  = bus.instr_valid_i ? dec : CTRL_BUBBLE;
        validD[0] = bus.instr_valid_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrlQ     <= '0;
      validQ    <= '0;
      stallCntQ <= '0;
      flushPend <= 1'b0;
    end else begin
      ctrlQ     <= ctrlD;
      validQ    <= validD;
      stallCntQ <= stallCntD;
      flushPend <= flushPendD;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.illegal_o   = bus.instr_valid_i && dec.illegal;
  assign bus.ctrl_o      = ctrlQ;
  assign bus.valid_o     = validQ;
  assign bus.stall_cnt_o = stallCntQ;

endmodule
